// File: rtl/multdiv_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
//
// Contents:
//   state_e      - controller state encoding {IDLE, MUL, DIV, DONE}
//   MULT_CYCLES  - start-to-DONE latency of a multiply (17 radix-4, 33 radix-2)
//   DIV_CYCLES   - start-to-DONE latency of a divide (33)
//   CNT_W        - iteration counter width
//   BOOTH_WIN_W  - multiplier window width fed to booth_recode (3 or 2)
//   PP_W         - signed partial-product / Booth adder width
//   BOOTH_SHIFT  - multiplier bits retired per Booth iteration
//   abs32()      - two's complement magnitude (0x80000000 maps to itself)
//
// Configuration macro: MULTDIV_RADIX4_EN selects radix-4 modified Booth;
// when undefined the multiplier uses radix-2 Booth.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

`ifdef MULTDIV_RADIX4_EN
    localparam int MULT_CYCLES = 17;
    localparam int BOOTH_WIN_W = 3;
    // +-2A needs two guard bits above the 32-bit accumulator
    localparam int PP_W        = 34;
`else
    localparam int MULT_CYCLES = 33;
    localparam int BOOTH_WIN_W = 2;
    localparam int PP_W        = 33;
`endif

    localparam int DIV_CYCLES  = 33;
    localparam int CNT_W       = 6;
    localparam int BOOTH_SHIFT = PP_W - 32;

    // Magnitude of a two's complement word, read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/multdiv_unit_booth_recode.sv
// Booth recoder: maps a multiplier window to the signed partial product that
// is added to the upper half of the product accumulator.
//
// Ports:
//   win_i   [BOOTH_WIN_W-1:0] - multiplier window, LSB is the previously
//                               retired bit (the "extra" bit)
//   mcand_i [31:0]            - multiplicand A, two's complement
//   pp_o    [PP_W-1:0]        - signed partial product (0/+-A, plus +-2A
//                               in radix-4)
//
// Configuration macro: MULTDIV_RADIX4_EN (3-bit window, 0/+-A/+-2A);
// undefined gives the 2-bit radix-2 window (0/+-A).
module booth_recode
    import multdiv_pkg::*;
(
    input  logic [BOOTH_WIN_W-1:0] win_i,
    input  logic [31:0]            mcand_i,
    output logic [PP_W-1:0]        pp_o
);

    logic [PP_W-1:0] a_ext_s;

    assign a_ext_s = {{(PP_W-32){mcand_i[31]}}, mcand_i};

    // Window decode to partial product.
    always_comb begin
        pp_o = {PP_W{1'b0}};
        case (win_i)
`ifdef MULTDIV_RADIX4_EN
            3'b001, 3'b010: pp_o = a_ext_s;
            3'b011:         pp_o = a_ext_s << 1;
            3'b100:         pp_o = {PP_W{1'b0}} - (a_ext_s << 1);
            3'b101, 3'b110: pp_o = {PP_W{1'b0}} - a_ext_s;
`else
            2'b01:          pp_o = a_ext_s;
            2'b10:          pp_o = {PP_W{1'b0}} - a_ext_s;
`endif
            default:        pp_o = {PP_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide responder for the execute stage.
// A one-cycle ctrl_MULT or ctrl_DIV pulse latches the operands; after a fixed
// latency the result and exception flag are registered and data_resultRDY
// strobes for one cycle. A new start in any state restarts the unit (MULT
// wins over DIV); an aborted operation produces no strobe.
//
// Ports:
//   clock          - rising-edge clock
//   reset          - asynchronous active-low reset
//   data_operandA  - multiplicand / dividend (two's complement)
//   data_operandB  - multiplier / divisor (two's complement)
//   ctrl_MULT      - start multiply
//   ctrl_DIV       - start divide
//   data_result    - product[31:0] or truncated quotient (registered)
//   data_exception - product overflow, divide by zero, or 0x80000000 / -1
//   data_resultRDY - one-cycle completion strobe
//
// Configuration macro: MULTDIV_RADIX4_EN selects radix-4 Booth (17-cycle
// multiply); undefined gives radix-2 Booth (33-cycle multiply). Divide is
// always 33 cycles.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    // Counter values at which the next edge enters DONE; the edges before
    // that each perform one iteration.
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Multiply: {upper product, multiplier/lower product, extra bit}
    logic [64:0]      mul_q;
    logic [31:0]      mcand_q;

    // Divide: signed partial remainder, dividend shifting into quotient
    logic [33:0]      rem_q;
    logic [31:0]      quo_q;
    logic [31:0]      dvsr_q;
    logic             neg_q;
    logic             dz_q;
    logic             ovf_q;

    logic [31:0]      result_q;
    logic             exc_q;
    logic             rdy_q;

    logic             start_s;
    logic [PP_W-1:0]  pp_s;
    logic [PP_W-1:0]  mul_sum_d;
    logic [64:0]      mul_d;
    logic             mul_ovf_d;
    logic [33:0]      div_shift_d;
    logic [33:0]      rem_d;
    logic [31:0]      quo_d;
    logic [31:0]      quo_final_d;

    assign start_s = ctrl_MULT | ctrl_DIV;

    booth_recode u_booth_recode (
        .win_i   (mul_q[BOOTH_WIN_W-1:0]),
        .mcand_i (mcand_q),
        .pp_o    (pp_s)
    );

    // Booth step: add the partial product to the sign-extended upper half,
    // then arithmetic-shift the whole accumulator right by BOOTH_SHIFT.
    // Dropping the retired low bits leaves the new window at the bottom.
    assign mul_sum_d = {{(PP_W-32){mul_q[64]}}, mul_q[64:33]} + pp_s;
    assign mul_d     = {mul_sum_d, mul_q[32:BOOTH_SHIFT]};

    // Product is mul_q[64:1]; overflow when its high word is not the
    // sign extension of bit 31.
    assign mul_ovf_d = (mul_q[64:33] != {32{mul_q[32]}});

    // Non-restoring step: subtract the divisor from a non-negative partial
    // remainder, add it to a negative one. Quotient bit is 1 when the new
    // remainder is non-negative, which makes the collected bits the exact
    // quotient; only the (discarded) remainder would need a fix-up.
    assign div_shift_d = {rem_q[32:0], quo_q[31]};
    assign rem_d       = rem_q[33] ? (div_shift_d + {2'b00, dvsr_q})
                                   : (div_shift_d - {2'b00, dvsr_q});
    assign quo_d       = {quo_q[30:0], ~rem_d[33]};

    // Sign fix-up; a zero divisor forces the architectural result to 0.
    // 0x80000000 / -1 needs no special case: the magnitude quotient is
    // already 0x80000000.
    assign quo_final_d = dz_q  ? 32'd0 :
                         neg_q ? (32'd0 - quo_q) : quo_q;

    // Controller, iteration datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            mul_q    <= 65'd0;
            mcand_q  <= 32'd0;
            rem_q    <= 34'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start_s) begin
                // Both datapaths are loaded; only the selected one iterates.
                state_q <= ctrl_MULT ? MUL : DIV;
                cnt_q   <= {CNT_W{1'b0}};
                mul_q   <= {32'd0, data_operandB, 1'b0};
                mcand_q <= data_operandA;
                rem_q   <= 34'd0;
                quo_q   <= abs32(data_operandA);
                dvsr_q  <= abs32(data_operandB);
                neg_q   <= data_operandA[31] ^ data_operandB[31];
                dz_q    <= (data_operandB == 32'd0);
                ovf_q   <= (data_operandA == 32'h8000_0000) &&
                           (data_operandB == 32'hFFFF_FFFF);
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    MUL: begin
                        if (cnt_q == MUL_LAST) begin
                            state_q  <= DONE;
                            result_q <= mul_q[32:1];
                            exc_q    <= mul_ovf_d;
                            rdy_q    <= 1'b1;
                        end else begin
                            mul_q <= mul_d;
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    DIV: begin
                        if (cnt_q == DIV_LAST) begin
                            state_q  <= DONE;
                            result_q <= quo_final_d;
                            exc_q    <= dz_q | ovf_q;
                            rdy_q    <= 1'b1;
                        end else begin
                            rem_q <= rem_d;
                            quo_q <= quo_d;
                            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed testbench for multdiv_unit. Build with or without
// MULTDIV_RADIX4_EN; the expected multiply latency follows the macro.
module tb_multdiv_unit;

`ifdef MULTDIV_RADIX4_EN
    localparam int MUL_N = 17;
`else
    localparam int MUL_N = 33;
`endif
    localparam int DIV_N = 33;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int tests_run = 0;
    int fails = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Issue one start pulse, then wait (bounded) for the strobe. lat is the
    // number of edges after the start edge at which RDY was seen, 0 if never.
    task automatic do_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic exc);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT = is_mul;
        ctrl_DIV = !is_mul;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
        lat = 0;
        res = 32'd0;
        exc = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                lat = k;
                res = data_result;
                exc = data_exception;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (data_result !== 32'd0) begin
            fails++;
            $display("FAIL reset_result: got %h expected %h", data_result, 32'd0);
        end
        tests_run++;
        if (data_exception !== 1'b0) begin
            fails++;
            $display("FAIL reset_exception: got %b expected 0", data_exception);
        end
        tests_run++;
        if (data_resultRDY !== 1'b0) begin
            fails++;
            $display("FAIL reset_rdy: got %b expected 0", data_resultRDY);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (data_resultRDY !== 1'b0) begin
            fails++;
            $display("FAIL idle_rdy: got %b expected 0", data_resultRDY);
        end
    endtask

    task automatic test_mul();
        logic [31:0] va [8] = '{32'h0000_0007, 32'h0001_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                                32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_8000};
        logic [31:0] vb [8] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'h0000_0001, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0001_0000};
        logic [31:0] vr [8] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000,
                                32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h8000_0000};
        logic        ve [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int lat;
        logic [31:0] res;
        logic exc;
        for (int i = 0; i < 8; i++) begin
            do_op(1'b1, va[i], vb[i], lat, res, exc);
            tests_run++;
            if (lat != MUL_N) begin
                fails++;
                $display("FAIL mul%0d_latency: got %0d expected %0d", i, lat, MUL_N);
            end
            tests_run++;
            if (res !== vr[i]) begin
                fails++;
                $display("FAIL mul%0d_result: %h*%h got %h expected %h", i, va[i], vb[i], res, vr[i]);
            end
            tests_run++;
            if (exc !== ve[i]) begin
                fails++;
                $display("FAIL mul%0d_exception: got %b expected %b", i, exc, ve[i]);
            end
            if (i == 0) begin
                @(posedge clock);
                #1;
                tests_run++;
                if (data_resultRDY !== 1'b0) begin
                    fails++;
                    $display("FAIL mul_strobe_width: rdy got %b expected 0", data_resultRDY);
                end
                tests_run++;
                if (data_result !== 32'hFFFF_FFEB) begin
                    fails++;
                    $display("FAIL mul_result_hold: got %h expected %h", data_result, 32'hFFFF_FFEB);
                end
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] va [10] = '{32'hFFFF_FF9C, 32'h0000_0005, 32'h8000_0000, 32'h0000_0064,
                                 32'h0000_0007, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] vb [10] = '{32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'h0000_0064, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001,
                                 32'h0000_0000, 32'h0000_0003};
        logic [31:0] vr [10] = '{32'hFFFF_FFF2, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFF2,
                                 32'h0000_0000, 32'hFFFF_FFFD, 32'h0000_0001, 32'h8000_0000,
                                 32'h0000_0000, 32'h2AAA_AAAA};
        logic        ve [10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        logic [31:0] res;
        logic exc;
        for (int i = 0; i < 10; i++) begin
            do_op(1'b0, va[i], vb[i], lat, res, exc);
            tests_run++;
            if (lat != DIV_N) begin
                fails++;
                $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, DIV_N);
            end
            tests_run++;
            if (res !== vr[i]) begin
                fails++;
                $display("FAIL div%0d_result: %h/%h got %h expected %h", i, va[i], vb[i], res, vr[i]);
            end
            tests_run++;
            if (exc !== ve[i]) begin
                fails++;
                $display("FAIL div%0d_exception: got %b expected %b", i, exc, ve[i]);
            end
        end
    endtask

    task automatic test_abort();
        int rdy_count = 0;
        int lat = 0;
        logic [31:0] res = 32'd0;
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_count++;
        end
        @(negedge clock);
        data_operandA = 32'd20;
        data_operandB = 32'd4;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                rdy_count++;
                if (lat == 0) begin
                    lat = k;
                    res = data_result;
                end
            end
        end
        tests_run++;
        if (rdy_count != 1) begin
            fails++;
            $display("FAIL abort_rdy_count: got %0d expected 1", rdy_count);
        end
        tests_run++;
        if (lat != DIV_N) begin
            fails++;
            $display("FAIL abort_latency: got %0d expected %0d", lat, DIV_N);
        end
        tests_run++;
        if (res !== 32'd5) begin
            fails++;
            $display("FAIL abort_result: got %h expected %h", res, 32'd5);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] res;
        logic exc;
        do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFD, lat, res, exc);
        tests_run++;
        if (res !== 32'hFFFF_FFEB || lat != MUL_N) begin
            fails++;
            $display("FAIL b2b_first: got %h lat %0d expected %h lat %0d", res, lat, 32'hFFFF_FFEB, MUL_N);
        end
        // This start is sampled on the edge where the unit sits in DONE.
        do_op(1'b0, 32'd20, 32'd4, lat, res, exc);
        tests_run++;
        if (lat != DIV_N) begin
            fails++;
            $display("FAIL b2b_latency: got %0d expected %0d", lat, DIV_N);
        end
        tests_run++;
        if (res !== 32'd5 || exc !== 1'b0) begin
            fails++;
            $display("FAIL b2b_result: got %h/%b expected %h/0", res, exc, 32'd5);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int rdy_count = 0;
        logic [31:0] res;
        logic exc;
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc);
        tests_run++;
        if (res !== 32'h8000_0000 || exc !== 1'b1) begin
            fails++;
            $display("FAIL prereset_div: got %h/%b expected %h/1", res, exc, 32'h8000_0000);
        end
        @(negedge clock);
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        tests_run++;
        if (data_result !== 32'h8000_0000 || data_exception !== 1'b1) begin
            fails++;
            $display("FAIL output_hold: got %h/%b expected %h/1", data_result, data_exception, 32'h8000_0000);
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (data_result !== 32'd0) begin
            fails++;
            $display("FAIL async_reset_result: got %h expected %h", data_result, 32'd0);
        end
        tests_run++;
        if (data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_flags: got exc %b rdy %b expected 0 0", data_exception, data_resultRDY);
        end
        // Starts presented while in reset must be ignored.
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        ctrl_MULT = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_count++;
        end
        tests_run++;
        if (rdy_count != 0) begin
            fails++;
            $display("FAIL post_reset_rdy: got %0d strobes expected 0", rdy_count);
        end
        do_op(1'b1, 32'd2, 32'd2, lat, res, exc);
        tests_run++;
        if (res !== 32'd4 || exc !== 1'b0 || lat != MUL_N) begin
            fails++;
            $display("FAIL post_reset_mul: got %h/%b lat %0d expected %h/0 lat %0d", res, exc, lat, 32'd4, MUL_N);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
